// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of the UART TX fifo between two byte-stream
// requesters: port 0 (game engine) and port 1 (debug/echo). A grant covers a
// whole packet, from the first byte up to and including the byte flagged
// 'last'. Packets are granted round-robin, so frames never interleave inside
// the fifo. A full fifo stalls the owner without losing data. An owner that
// stops presenting bytes in the middle of a packet is released after TIMEOUT
// idle cycles.
//
// State table
//   state | meaning
//   IDLE  | no grant held; arbitrate among requesters, nothing written
//   OWN0  | port 0 holds the write port until its 'last' byte or a timeout
//   OWN1  | port 1 holds the write port until its 'last' byte or a timeout
//
// Ports
//   clk          in   1           system clock, rising edge
//   reset_n      in   1           asynchronous, active-low reset
//   req0         in   1           port 0 has a valid byte on data0
//   data0        in   DATA_WIDTH  port 0 byte
//   last0        in   1           data0 is the final byte of its packet
//   ack0         out  1           port 0 byte written this cycle
//   req1         in   1           port 1 has a valid byte on data1
//   data1        in   DATA_WIDTH  port 1 byte
//   last1        in   1           data1 is the final byte of its packet
//   ack1         out  1           port 1 byte written this cycle
//   fifo_full    in   1           fifo full flag
//   fifo_wr      out  1           fifo write strobe
//   fifo_w_data  out  DATA_WIDTH  fifo write data
//   busy         out  1           a packet grant is held
//   owner        out  1           port holding the grant (valid when busy)
//   timeout_err  out  1           one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int TO_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic                  last0,
    output logic                  ack0,

    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  last1,
    output logic                  ack1,

    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_w_data,

    output logic                  busy,
    output logic                  owner,
    output logic                  timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Idle count at which the next idle cycle forces the release.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_rr_ptr;
    logic [TO_WIDTH-1:0] r_idle_cnt;
    logic                r_timeout_err;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic                w_own0;
    logic                w_own1;
    logic                w_owned;
    logic                w_ack0;
    logic                w_ack1;
    logic                w_own_req;
    logic                w_own_last;
    logic                w_pkt_done;
    logic                w_idle_tick;
    logic                w_timeout;

    logic [1:0]          w_state_nxt;
    logic                w_rr_ptr_nxt;
    logic [TO_WIDTH-1:0] w_idle_cnt_nxt;

    assign w_own0  = (r_state == ST_OWN0);
    assign w_own1  = (r_state == ST_OWN1);
    assign w_owned = w_own0 | w_own1;

    // Acks depend on the current inputs, so a requester sees its byte accepted
    // in the same cycle it is presented and can advance on the next edge.
    assign w_ack0 = w_own0 & req0 & ~fifo_full;
    assign w_ack1 = w_own1 & req1 & ~fifo_full;

    assign w_own_req  = w_own1 ? req1  : req0;
    assign w_own_last = w_own1 ? last1 : last0;

    // 'last' only counts when the byte carrying it is actually written.
    assign w_pkt_done = (w_ack0 | w_ack1) & w_own_last;

    // A full fifo freezes the owner entirely, including its idle count, so a
    // slow drain never turns into a spurious timeout.
    assign w_idle_tick = w_owned & ~w_own_req & ~fifo_full;
    assign w_timeout   = w_idle_tick & (r_idle_cnt == TO_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_idle_cnt_nxt = r_idle_cnt;

        case (r_state)
            ST_IDLE: begin
                w_idle_cnt_nxt = '0;
                if (req0 && req1) begin
                    w_state_nxt = r_rr_ptr ? ST_OWN1 : ST_OWN0;
                end else if (req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (w_pkt_done || w_timeout) begin
                    // Hand the next tie to the port that did not just own.
                    w_state_nxt    = ST_IDLE;
                    w_rr_ptr_nxt   = ~w_own1;
                    w_idle_cnt_nxt = '0;
                end else if (!fifo_full) begin
                    if (w_own_req) begin
                        w_idle_cnt_nxt = '0;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + TO_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_idle_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= 1'b0;
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_timeout_err <= w_timeout;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Reset forces IDLE asynchronously, which zeroes every decoded output
    // without waiting for a clock edge.
    assign ack0        = w_ack0;
    assign ack1        = w_ack1;
    assign fifo_wr     = w_ack0 | w_ack1;
    assign fifo_w_data = w_own0 ? data0 :
                         w_own1 ? data1 : '0;
    assign busy        = w_owned;
    assign owner       = w_own1;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Inputs are applied on the falling edge
// and outputs are sampled 1 ns later, well away from the rising edge. All
// expected values are written out by hand per cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       fifo_full = 1'b0;
    logic       ack0, ack1, fifo_wr, busy, owner, timeout_err;
    logic [7:0] fifo_w_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .TIMEOUT    (16),
        .TO_WIDTH   (5)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0        (req0),
        .data0       (data0),
        .last0       (last0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .last1       (last1),
        .ack1        (ack1),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic wr, input logic [7:0] wd,
                              input logic a0, input logic a1, input logic bz,
                              input logic ow, input logic te);
        chk_eq($sformatf("%s.fifo_wr", tag), 32'(fifo_wr), 32'(wr));
        chk_eq($sformatf("%s.w_data", tag), 32'(fifo_w_data), 32'(wd));
        chk_eq($sformatf("%s.ack0", tag), 32'(ack0), 32'(a0));
        chk_eq($sformatf("%s.ack1", tag), 32'(ack1), 32'(a1));
        chk_eq($sformatf("%s.busy", tag), 32'(busy), 32'(bz));
        chk_eq($sformatf("%s.owner", tag), 32'(owner), 32'(ow));
        chk_eq($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(te));
    endtask

    // Apply one cycle of requester/fifo inputs on the falling edge.
    task automatic drv(input logic r0, input logic [7:0] d0, input logic l0,
                       input logic r1, input logic [7:0] d1, input logic l1,
                       input logic f);
        @(negedge clk);
        req0 = r0; data0 = d0; last0 = l0;
        req1 = r1; data1 = d1; last1 = l1;
        fifo_full = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b0; data0 = '0; last0 = 1'b0;
        req1 = 1'b0; data1 = '0; last1 = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset held with port 0 requesting -> nothing granted or written
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'h55, 0, 0, 8'h00, 0, 0);
            expect_out($sformatf("t1_rst%0d", i), 0, 8'h00, 0, 0, 0, 0, 0);
        end
        do_reset();

        // T3: contention right after reset (rr_ptr=0): port 0 first
        drv(1, 8'h1A, 0, 1, 8'h2A, 0, 0); expect_out("t3_arb",  0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h1A, 0, 1, 8'h2A, 0, 0); expect_out("t3_1A",   1, 8'h1A, 1, 0, 1, 0, 0);
        drv(1, 8'h1B, 1, 1, 8'h2A, 0, 0); expect_out("t3_1B",   1, 8'h1B, 1, 0, 1, 0, 0);
        // port 0 re-requests immediately; port 1 must win this tie
        drv(1, 8'h1C, 0, 1, 8'h2A, 0, 0); expect_out("t3_arb2", 0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h1C, 0, 1, 8'h2A, 0, 0); expect_out("t3_2A",   1, 8'h2A, 0, 1, 1, 1, 0);
        drv(1, 8'h1C, 0, 1, 8'h2B, 1, 0); expect_out("t3_2B",   1, 8'h2B, 0, 1, 1, 1, 0);
        drv(1, 8'h1C, 0, 0, 8'h00, 0, 0); expect_out("t3_arb3", 0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h1C, 0, 0, 8'h00, 0, 0); expect_out("t3_1C",   1, 8'h1C, 1, 0, 1, 0, 0);
        drv(1, 8'h1D, 1, 0, 8'h00, 0, 0); expect_out("t3_1D",   1, 8'h1D, 1, 0, 1, 0, 0);
        drv(0, 8'h00, 0, 0, 8'h00, 0, 0); expect_out("t3_end",  0, 8'h00, 0, 0, 0, 0, 0);

        // T2: single packet 0A,0B,0C from port 0, with a stray 'last' while
        // req0 is low that must be ignored
        drv(1, 8'h0A, 0, 0, 8'h00, 0, 0); expect_out("t2_arb",  0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h0A, 0, 0, 8'h00, 0, 0); expect_out("t2_0A",   1, 8'h0A, 1, 0, 1, 0, 0);
        drv(1, 8'h0B, 0, 0, 8'h00, 0, 0); expect_out("t2_0B",   1, 8'h0B, 1, 0, 1, 0, 0);
        drv(0, 8'h0C, 1, 0, 8'h00, 0, 0); expect_out("t2_nolst",0, 8'h0C, 0, 0, 1, 0, 0);
        drv(1, 8'h0C, 1, 0, 8'h00, 0, 0); expect_out("t2_0C",   1, 8'h0C, 1, 0, 1, 0, 0);
        drv(0, 8'h00, 0, 0, 8'h00, 0, 0); expect_out("t2_end",  0, 8'h00, 0, 0, 0, 0, 0);

        // T4: fifo full mid-packet stalls everything, including the idle count
        drv(1, 8'h41, 0, 0, 8'h00, 0, 0); expect_out("t4_arb",  0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h41, 0, 0, 8'h00, 0, 0); expect_out("t4_41",   1, 8'h41, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'h42, 0, 0, 8'h00, 0, 1);
            expect_out($sformatf("t4_full%0d", i), 0, 8'h42, 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            drv(0, 8'h42, 0, 0, 8'h00, 0, 1);
            expect_out($sformatf("t4_fidle%0d", i), 0, 8'h42, 0, 0, 1, 0, 0);
        end
        drv(1, 8'h42, 0, 0, 8'h00, 0, 0); expect_out("t4_42",   1, 8'h42, 1, 0, 1, 0, 0);
        drv(1, 8'h43, 1, 0, 8'h00, 0, 0); expect_out("t4_43",   1, 8'h43, 1, 0, 1, 0, 0);
        drv(0, 8'h00, 0, 0, 8'h00, 0, 0); expect_out("t4_end",  0, 8'h00, 0, 0, 0, 0, 0);

        // T5: port 1 writes 0x33 then goes quiet; port 0 waits with a
        // single-byte packet
        drv(0, 8'h00, 0, 1, 8'h33, 0, 0); expect_out("t5_arb",  0, 8'h00, 0, 0, 0, 0, 0);
        drv(0, 8'h00, 0, 1, 8'h33, 0, 0); expect_out("t5_33",   1, 8'h33, 0, 1, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            drv(1, 8'h55, 1, 0, 8'h33, 0, 0);
            expect_out($sformatf("t5_idle%0d", i), 0, 8'h33, 0, 0, 1, 1, 0);
        end
        drv(1, 8'h55, 1, 0, 8'h33, 0, 0); expect_out("t5_terr", 0, 8'h00, 0, 0, 0, 0, 1);
        drv(1, 8'h55, 1, 0, 8'h33, 0, 0); expect_out("t5_55",   1, 8'h55, 1, 0, 1, 0, 0);
        drv(0, 8'h00, 0, 0, 8'h00, 0, 0); expect_out("t5_end",  0, 8'h00, 0, 0, 0, 0, 0);

        // T6: reset in the middle of a 4-byte packet from port 0
        drv(1, 8'h61, 0, 0, 8'h00, 0, 0); expect_out("t6_arb",  0, 8'h00, 0, 0, 0, 0, 0);
        drv(1, 8'h61, 0, 0, 8'h00, 0, 0); expect_out("t6_61",   1, 8'h61, 1, 0, 1, 0, 0);
        drv(1, 8'h62, 0, 0, 8'h00, 0, 0); expect_out("t6_62",   1, 8'h62, 1, 0, 1, 0, 0);
        @(negedge clk);
        data0   = 8'h63;
        reset_n = 1'b0;
        #1;
        expect_out("t6_rst", 0, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        req0    = 1'b0;
        reset_n = 1'b1;
        #1;
        expect_out("t6_rel", 0, 8'h00, 0, 0, 0, 0, 0);
        drv(0, 8'h00, 0, 1, 8'h71, 1, 0); expect_out("t6_arb2", 0, 8'h00, 0, 0, 0, 0, 0);
        drv(0, 8'h00, 0, 1, 8'h71, 1, 0); expect_out("t6_71",   1, 8'h71, 0, 1, 1, 1, 0);
        drv(0, 8'h00, 0, 0, 8'h00, 0, 0); expect_out("t6_end",  0, 8'h00, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
